// File: rtl/fetch_ctrl_if.sv
// ============================================================================
// Module  : fetch_ctrl_if
// Purpose : Fetch-sequencer bundle: instruction-memory request/response port
//           plus the decode/execute handshake and status outputs.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_ctrl_if #(
    parameter int CPU_WIDTH = 32
);
    logic                 imem_req_valid;
    logic [CPU_WIDTH-1:0] imem_req_addr;
    logic                 imem_req_ready;
    logic                 imem_rsp_valid;
    logic [31:0]          imem_rsp_inst;

    logic                 inst_valid;
    logic [31:0]          inst;
    logic [CPU_WIDTH-1:0] curr_pc;
    logic                 commit;
    logic [CPU_WIDTH-1:0] next_pc;
    logic                 halt_req;

    logic                 halted;
    logic                 trap;
    logic [CPU_WIDTH-1:0] trap_pc;
    logic [31:0]          instret;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_inst,
        output inst_valid, inst, curr_pc,
        input  commit, next_pc, halt_req,
        output halted, trap, trap_pc, instret
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_inst,
        input  inst_valid, inst, curr_pc,
        output commit, next_pc, halt_req,
        input  halted, trap, trap_pc, instret
    );
endinterface

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module  : fetch_ctrl
// Purpose : Single-outstanding instruction-fetch sequencer owning the PC,
//           retired-instruction counter and halt/misaligned-target trap.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_ctrl #(
    parameter int                   CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h8000_0000
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    fetch_ctrl_if.master    bus
);

    typedef enum logic [2:0] {
        S_BOOT     = 3'd0,
        S_REQ      = 3'd1,
        S_WAIT_RSP = 3'd2,
        S_EXEC     = 3'd3,
        S_HALT     = 3'd4,
        S_TRAP     = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [CPU_WIDTH-1:0] r_pc;
    logic [31:0]          r_inst;
    logic                 r_inst_valid;
    logic [CPU_WIDTH-1:0] r_trap_pc;
    logic [31:0]          r_instret;

    logic                 w_take_rsp;
    logic                 w_retire;
    logic                 w_redirect;
    logic                 w_misalign;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and event decode; halt wins over a misaligned target
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_take_rsp  = 1'b0;
        w_retire    = 1'b0;
        w_redirect  = 1'b0;
        w_misalign  = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (bus.imem_req_ready) begin
                    w_state_nxt = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (bus.imem_rsp_valid) begin
                    w_take_rsp  = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bus.commit) begin
                    if (bus.halt_req) begin
                        w_retire    = 1'b1;
                        w_state_nxt = S_HALT;
                    end else if (bus.next_pc[1:0] != 2'b00) begin
                        w_misalign  = 1'b1;
                        w_state_nxt = S_TRAP;
                    end else begin
                        w_retire    = 1'b1;
                        w_redirect  = 1'b1;
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_HALT, S_TRAP: begin
                w_state_nxt = r_state;
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_inst       <= 32'd0;
            r_inst_valid <= 1'b0;
            r_trap_pc    <= '0;
            r_instret    <= 32'd0;
        end else begin
            // Pulses only on the cycle EXEC is entered
            r_inst_valid <= w_take_rsp;
            if (w_take_rsp) begin
                r_inst <= bus.imem_rsp_inst;
            end
            if (w_redirect) begin
                r_pc <= bus.next_pc;
            end
            if (w_misalign) begin
                r_trap_pc <= bus.next_pc;
            end
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    // Status and request valid come straight from the state register
    assign bus.imem_req_valid = (r_state == S_REQ);
    assign bus.halted         = (r_state == S_HALT);
    assign bus.trap           = (r_state == S_TRAP);

    assign bus.imem_req_addr  = r_pc;
    assign bus.curr_pc        = r_pc;
    assign bus.inst           = r_inst;
    assign bus.inst_valid     = r_inst_valid;
    assign bus.trap_pc        = r_trap_pc;
    assign bus.instret        = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module  : tb_fetch_ctrl
// Purpose : Directed self-checking bench for fetch_ctrl with a cycle model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic preload = 1'b0;

    int errs   = 0;
    int checks = 0;

    fetch_ctrl_if #(.CPU_WIDTH(32)) bus ();

    fetch_ctrl #(
        .CPU_WIDTH (32),
        .RESET_PC  (RST_PC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Reference model: what the sequencer is doing, tracked as activity flags
    bit          m_booting, m_requesting, m_outstanding, m_executing;
    bit          m_halted, m_trapped, m_fresh;
    logic [31:0] m_pc, m_inst, m_trap_pc, m_instret;

    always @(posedge clk or negedge rst_n or posedge preload) begin
        if (!rst_n) begin
            m_booting = 1; m_requesting = 0; m_outstanding = 0; m_executing = 0;
            m_halted = 0; m_trapped = 0; m_fresh = 0;
            m_pc = RST_PC; m_inst = 0; m_trap_pc = 0; m_instret = 0;
        end else if (preload) begin
            m_instret = 32'hFFFF_FFFF;
        end else begin
            m_fresh = 0;
            if (m_booting) begin
                m_booting = 0;
                m_requesting = 1;
            end else if (m_requesting && bus.imem_req_ready) begin
                m_requesting = 0;
                m_outstanding = 1;
            end else if (m_outstanding && bus.imem_rsp_valid) begin
                m_outstanding = 0;
                m_executing = 1;
                m_inst = bus.imem_rsp_inst;
                m_fresh = 1;
            end else if (m_executing && bus.commit) begin
                m_executing = 0;
                if (bus.halt_req) begin
                    m_instret = m_instret + 1;
                    m_halted = 1;
                end else if (bus.next_pc % 4 != 0) begin
                    m_trap_pc = bus.next_pc;
                    m_trapped = 1;
                end else begin
                    m_pc = bus.next_pc;
                    m_instret = m_instret + 1;
                    m_requesting = 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("req_valid",  {31'd0, bus.imem_req_valid}, {31'd0, m_requesting});
        chk("req_addr",   bus.imem_req_addr, m_pc);
        chk("curr_pc",    bus.curr_pc,       m_pc);
        chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, m_fresh});
        chk("inst",       bus.inst,          m_inst);
        chk("halted",     {31'd0, bus.halted}, {31'd0, m_halted});
        chk("trap",       {31'd0, bus.trap},   {31'd0, m_trapped});
        chk("trap_pc",    bus.trap_pc,       m_trap_pc);
        chk("instret",    bus.instret,       m_instret);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_commit(input logic [31:0] npc, input logic halt);
        bus.commit = 1'b1; bus.next_pc = npc; bus.halt_req = halt;
        step();
        bus.commit = 1'b0; bus.halt_req = 1'b0;
    endtask

    // Entered in REQ; leaves the DUT in its first EXEC cycle
    task automatic do_fetch(input int wait_rdy, input int wait_rsp,
                            input logic [31:0] word, input logic spur);
        for (int i = 0; i < wait_rdy; i++) begin
            bus.imem_req_ready = 1'b0;
            bus.imem_rsp_valid = spur;
            bus.imem_rsp_inst  = 32'hDEAD_BEEF;
            step();
        end
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = spur;
        bus.imem_rsp_inst  = 32'hDEAD_BEEF;
        step();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        for (int i = 0; i < wait_rsp; i++) begin
            bus.commit  = spur;
            bus.next_pc = 32'h1234_5678;
            step();
        end
        bus.commit = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_inst  = word;
        step();
        bus.imem_rsp_valid = 1'b0;
    endtask

    task automatic reset_boot();
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.commit = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_inst = 32'd0;
        bus.commit = 1'b0; bus.next_pc = 32'd0; bus.halt_req = 1'b0;
        #1 rst_n = 1'b0;
        step(); step(); step();
        chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        chk("rst_pc",        bus.curr_pc, 32'h8000_0000);
        chk("rst_instret",   bus.instret, 32'd0);

        // Boot: request in cycle 1, instruction pulse in cycle 3
        rst_n = 1'b1; bus.imem_req_ready = 1'b1;
        step();
        chk("boot_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("boot_addr",      bus.imem_req_addr, 32'h8000_0000);
        step();
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_inst = 32'h0000_0013;
        step();
        bus.imem_rsp_valid = 1'b0;
        chk("boot_inst_valid", {31'd0, bus.inst_valid}, 32'd1);
        chk("boot_inst",       bus.inst, 32'h0000_0013);

        // Sequential commits with back-pressure and spurious inputs
        do_commit(RST_PC + 4, 1'b0);
        do_fetch(5, 0, 32'h0010_0093, 1'b1);
        chk("bp_pc",   bus.curr_pc, 32'h8000_0004);
        chk("bp_inst", bus.inst,    32'h0010_0093);
        do_commit(RST_PC + 8, 1'b0);
        do_fetch(0, 2, 32'h0020_0113, 1'b1);
        chk("spur_inst",    bus.inst,    32'h0020_0113);
        chk("spur_instret", bus.instret, 32'd2);
        do_commit(RST_PC + 12, 1'b0);
        do_fetch(1, 1, 32'h0030_0193, 1'b0);
        chk("seq_pc",      bus.curr_pc, 32'h8000_000C);
        chk("seq_instret", bus.instret, 32'd3);

        // Misaligned target traps without retiring
        do_commit(32'h8000_0102, 1'b0);
        chk("trap_flag",    {31'd0, bus.trap}, 32'd1);
        chk("trap_pc_lit",  bus.trap_pc, 32'h8000_0102);
        chk("trap_instret", bus.instret, 32'd3);
        chk("trap_pc_hold", bus.curr_pc, 32'h8000_000C);
        bus.imem_req_ready = 1'b1;
        bus.commit = 1'b1;
        repeat (4) step();
        bus.commit = 1'b0;

        // Halt beats misalignment on the same commit
        reset_boot();
        do_fetch(0, 0, 32'h0010_0073, 1'b0);
        do_commit(32'h8000_0102, 1'b1);
        chk("halt_flag",    {31'd0, bus.halted}, 32'd1);
        chk("halt_notrap",  {31'd0, bus.trap},   32'd0);
        chk("halt_instret", bus.instret, 32'd1);
        bus.imem_req_ready = 1'b1;
        repeat (3) step();

        // Reset while a response is outstanding
        reset_boot();
        do_fetch(0, 0, 32'h0000_0513, 1'b0);
        do_commit(RST_PC + 4, 1'b0);
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_inst",    bus.inst,    32'd0);
        chk("mid_rst_pc",      bus.curr_pc, 32'h8000_0000);
        chk("mid_rst_instret", bus.instret, 32'd0);
        step();
        rst_n = 1'b1;
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_inst = 32'h0BAD_0BAD;
        step();
        bus.imem_rsp_valid = 1'b0;
        chk("stale_rsp_inst", bus.inst, 32'd0);
        chk("restart_addr",   bus.imem_req_addr, 32'h8000_0000);
        do_fetch(0, 0, 32'h0000_0013, 1'b0);

        // Retired counter wraps silently
        force dut.r_instret = 32'hFFFF_FFFF;
        preload = 1'b1;
        #1 preload = 1'b0;
        step();
        release dut.r_instret;
        #1;
        chk("preload_instret", bus.instret, 32'hFFFF_FFFF);
        do_commit(RST_PC + 4, 1'b0);
        chk("wrap_instret", bus.instret, 32'd0);
        chk("wrap_pc",      bus.curr_pc, 32'h8000_0004);
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the multi-cycle core. It owns the architectural PC register and issues one fetch at a time to instruction memory over a valid/ready request port. It presents the fetched instruction to decode/execute and waits for execute to commit. On commit it loads the next-PC value computed by the next-PC logic, detects halt and misaligned targets, and keeps a retired-instruction counter.

## Interface
Parameters:
- `CPU_WIDTH`, 32, datapath/address width.
- `RESET_PC`, 32'h8000_0000, PC after reset; must be 4-byte aligned.

Ports:
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_addr` output CPU_WIDTH: fetch address, always equal to `curr_pc`.
- `imem_req_ready` input 1: memory accepts the request this cycle.
- `imem_rsp_valid` input 1: instruction response valid.
- `imem_rsp_inst` input 32: response instruction word.
- `inst_valid` output 1: one-cycle pulse, `inst` is newly valid.
- `inst` output 32: latched instruction, held until the next response.
- `curr_pc` output CPU_WIDTH: PC of the instruction being fetched or executed.
- `commit` input 1: execute finished the current instruction.
- `next_pc` input CPU_WIDTH: next-PC value, sampled only on an accepted commit.
- `halt_req` input 1: the committing instruction is ebreak/halt, sampled with commit.
- `halted` output 1: core halted, sticky.
- `trap` output 1: misaligned-target trap, sticky.
- `trap_pc` output CPU_WIDTH: offending target address.
- `instret` output 32: retired-instruction count.

## Operation
- States: BOOT, REQ, WAIT_RSP, EXEC, HALT, TRAP.
- **Reset values:** state BOOT, `curr_pc` = RESET_PC, `imem_req_valid` 0, `inst` 0, `inst_valid` 0, `halted` 0, `trap` 0, `trap_pc` 0, `instret` 0.
- **BOOT:** always goes to REQ on the next cycle.
- **REQ:** `imem_req_valid` = 1. Go to WAIT_RSP when `imem_req_ready` = 1. While valid=1 and ready=0, the address stays stable.
- **WAIT_RSP:** on `imem_rsp_valid`, register `imem_rsp_inst` into `inst`, pulse `inst_valid`, go to EXEC.
- **EXEC:** wait for `commit`.
  - `halt_req` = 1: increment `instret`, go to HALT.
  - else `next_pc[1:0]` != 0: `trap_pc` <= `next_pc`, go to TRAP. `instret` is not incremented and `curr_pc` is unchanged.
  - else: `curr_pc` <= `next_pc`, increment `instret`, go to REQ.
- **HALT / TRAP:** terminal until reset. `halted` / `trap` = 1, `imem_req_valid` = 0.
- `commit` outside EXEC is ignored.
- `imem_rsp_valid` outside WAIT_RSP is ignored (stale or spurious responses are dropped).
- Only one fetch may be outstanding at a time.
- `instret` wraps from 32'hFFFF_FFFF to 0 without a flag.
- `halt_req` takes priority over a misaligned `next_pc` on the same commit.

## Timing
- `imem_req_valid`, `halted`, and `trap` are decoded from registered state only, with no combinational path from inputs.
- A response may arrive no earlier than the cycle after request acceptance. A response in the same cycle as acceptance is ignored.
- `inst_valid` is high for exactly the first cycle of EXEC (registered). `inst` and `curr_pc` are valid in that cycle.
- `commit` may arrive in the first EXEC cycle.
- With ready=1 and a 1-cycle memory, the minimum cycles per instruction is 3 (REQ, WAIT_RSP, EXEC). First `imem_req_valid` appears 1 cycle after `rst_n` deasserts.
- Commit-to-next-request latency is 1 cycle: updated `curr_pc` and `imem_req_valid` appear together.
- Assertion of `rst_n` = 0 in any state forces reset values immediately. A response in flight at reset is dropped.

## Test plan
- **Reset/boot:** release `rst_n`; ready=1, rsp one cycle later with 32'h00000013 -> `imem_req_addr` = RESET_PC in cycle 1, `inst_valid` pulse in cycle 3 with `inst` = 32'h00000013.
- **Back-pressure:** ready=0 for 5 cycles -> valid held high with constant address; single acceptance on ready; no duplicate request.
- **Sequential commits:** commit with `next_pc` = `curr_pc`+4 three times -> addresses RESET_PC+4, +8, +12; `instret` = 3.
- **Misaligned target:** commit with `next_pc` = 32'h8000_0102 -> `trap` = 1, `trap_pc` = 32'h8000_0102, `instret` unchanged, no further requests. Same commit with `halt_req` = 1 -> `halted` = 1 and `trap` = 0.
- **Spurious inputs:** rsp_valid during REQ and commit during WAIT_RSP -> ignored; `inst`, `curr_pc`, and `instret` unchanged.
- **Reset mid-fetch:** assert `rst_n` = 0 in WAIT_RSP, then deliver the response after release -> response dropped; all outputs at reset values; fetch restarts at RESET_PC. Also preload `instret` to 32'hFFFF_FFFF via commits (or force) and commit once -> wraps to 0.
